vga_timing_xga: RTL

Free-running raster timing generator for the 1024x768@60 Hz display path (65 MHz pixel clock). Produces the pixel/line counters, blanking flags and sync pulses consumed by the menu/scene drawing stages (hcount/vcount/hblnk/vblnk inputs of the draw stage). Sits directly upstream of every draw stage. It is the sole source of raster position in the design.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_axis_timer.sv | 61 ++++++
 rtl/vga_timing_xga.sv | 60 ++++++
 3 files changed

// File: rtl/vga_pkg.sv
// XGA 1024x768@60 raster constants shared by the timing generator and the draw stages.
`timescale 1ns/1ps
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FRONT  = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BACK   = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 768;
  localparam int V_FRONT  = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BACK   = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // Screen-edge coordinates used by the draw stages for clipping.
  localparam int H_LAST_PIXEL = H_ACTIVE - 1;
  localparam int V_LAST_LINE  = V_ACTIVE - 1;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: enabled counter with wrap, plus blank and sync flags decoded from the
// next count so they line up with the registered count on the same cycle.
`timescale 1ns/1ps
module vga_axis_timer #(
  parameter int ACTIVE          = 1024,
  parameter int FRONT           = 24,
  parameter int SYNC            = 136,
  parameter int BACK            = 160,
  parameter int W               = 11,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count_out,
  output logic         blnk_out,
  output logic         sync_out,
  output logic         wrap_out
);

  localparam int   TOTAL      = ACTIVE + FRONT + SYNC + BACK;
  localparam int   SYNC_START = ACTIVE + FRONT;
  localparam int   SYNC_END   = SYNC_START + SYNC - 1;
  localparam logic SYNC_IDLE  = (SYNC_ACTIVE_LOW != 0);

  logic [W-1:0] count_q, count_d;
  logic         blnk_q, blnk_d;
  logic         sync_q, sync_d;
  logic         wrap;

  always_comb begin
    wrap    = en && (count_q == W'(TOTAL - 1));
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
    blnk_d = (count_d >= W'(ACTIVE));
    // XOR with the idle level turns "inside sync window" into the pin polarity.
    sync_d = ((count_d >= W'(SYNC_START)) && (count_d <= W'(SYNC_END))) ^ SYNC_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= SYNC_IDLE;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count_out = count_q;
  assign blnk_out  = blnk_q;
  assign sync_out  = sync_q;
  assign wrap_out  = wrap;

endmodule

// File: rtl/vga_timing_xga.sv
// Free-running XGA raster timing generator: horizontal axis always counts, vertical axis
// advances on horizontal wrap; all outputs registered with zero skew between them.
`timescale 1ns/1ps
module vga_timing_xga #(
  parameter int H_ACTIVE        = vga_pkg::H_ACTIVE,
  parameter int H_FRONT         = vga_pkg::H_FRONT,
  parameter int H_SYNC          = vga_pkg::H_SYNC,
  parameter int H_BACK          = vga_pkg::H_BACK,
  parameter int V_ACTIVE        = vga_pkg::V_ACTIVE,
  parameter int V_FRONT         = vga_pkg::V_FRONT,
  parameter int V_SYNC          = vga_pkg::V_SYNC,
  parameter int V_BACK          = vga_pkg::V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [vga_pkg::HCNT_W-1:0]  hcount_out,
  output logic [vga_pkg::VCNT_W-1:0]  vcount_out,
  output logic                        hblnk_out,
  output logic                        vblnk_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        frame_start_out
);

  logic h_wrap, v_wrap;
  logic frame_start_q, frame_start_d;

  vga_axis_timer #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .W(vga_pkg::HCNT_W), .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_h_axis (
    .clk(clk), .rst(rst), .en(1'b1),
    .count_out(hcount_out), .blnk_out(hblnk_out), .sync_out(hsync_out), .wrap_out(h_wrap)
  );

  vga_axis_timer #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .W(vga_pkg::VCNT_W), .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
  ) u_v_axis (
    .clk(clk), .rst(rst), .en(h_wrap),
    .count_out(vcount_out), .blnk_out(vblnk_out), .sync_out(vsync_out), .wrap_out(v_wrap)
  );

  // Both axes wrapping on this edge means the next raster position is (0,0) of a new frame.
  always_comb begin
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start_out = frame_start_q;

endmodule
